// File: rtl/hdmi_cfg_seq.sv
// Table-driven configuration sequencer for the SiI9134 HDMI transmitter.
// Walks a synchronous command ROM after a power-up wait. Each 25-bit entry is
// an I2C register write, a timed delay, a NOP or an end marker. Writes go to an
// external I2C byte-write master over a req/done handshake and are retried on
// NACK. cfg_done (gates video start) or cfg_err is raised and held at the end.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   start              one-cycle (re)run pulse, honoured in IDLE/DONE/ERR only
//   tbl_addr/tbl_data  ROM address out, entry in (1-cycle read latency)
//                      entry: [24:23] op, [22:16] dev, [15:8] reg, [7:0] val
//   i2c_req            registered write request, held until i2c_done
//   i2c_dev/reg/wdata  write fields, stable while i2c_req is high
//   i2c_done/i2c_nack  transfer finished pulse / slave NACKed (with done)
//   busy               sequence in progress
//   cfg_done/cfg_err   terminal status, mutually exclusive
//   err_addr           table index of the entry that exhausted its retries
module hdmi_cfg_seq #(
    parameter int unsigned TBL_AW     = 6,
    parameter logic [19:0] PWRUP_CYC  = 20'd740000,
    parameter logic [15:0] TICK_CYC   = 16'd74,
    parameter int unsigned MAX_RETRY  = 3,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [24:0]       tbl_data,
    output logic              i2c_req,
    output logic [6:0]        i2c_dev,
    output logic [7:0]        i2c_reg,
    output logic [7:0]        i2c_wdata,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [TBL_AW-1:0] err_addr
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);

    typedef enum logic [1:0] {
        OpWrite = 2'b00,
        OpDelay = 2'b01,
        OpEnd   = 2'b10,
        OpNop   = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        StIdle,
        StPwrup,
        StFetch,
        StDecode,
        StWrite,
        StWaitI2c,
        StDelay,
        StNext,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [TBL_AW-1:0] addr_q, addr_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              req_q, req_d;
    logic [6:0]        dev_q, dev_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        val_q, val_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TBL_AW-1:0] erra_q, erra_d;
    logic              auto_q, auto_d;
    logic [19:0]       pwr_q, pwr_d;
    logic [15:0]       tick_q, tick_d;
    logic [15:0]       cyc_q, cyc_d;

    op_e dec_op;
    assign dec_op = op_e'(tbl_data[24:23]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        retry_d = retry_q;
        req_d   = req_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        val_d   = val_q;
        done_d  = done_q;
        err_d   = err_q;
        erra_d  = erra_q;
        auto_d  = auto_q;
        pwr_d   = pwr_q;
        tick_d  = tick_q;
        cyc_d   = cyc_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                // auto_q is only ever set while sitting in IDLE straight out of reset
                if (start || auto_q) begin
                    auto_d  = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    erra_d  = '0;
                    retry_d = '0;
                    pwr_d   = PWRUP_CYC;
                    state_d = StPwrup;
                end
            end
            StPwrup: begin
                if (pwr_q <= 20'd1) begin
                    addr_d  = '0;
                    state_d = StFetch;
                end else begin
                    pwr_d = pwr_q - 20'd1;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                unique case (dec_op)
                    OpWrite: state_d = StWrite;
                    OpDelay: begin
                        if (tbl_data[15:0] == 16'd0) begin
                            state_d = StNext;
                        end else begin
                            tick_d  = tbl_data[15:0];
                            cyc_d   = TICK_CYC;
                            state_d = StDelay;
                        end
                    end
                    OpEnd: begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                    OpNop: state_d = StNext;
                endcase
            end
            StWrite: begin
                // tbl_addr has not moved since FETCH, so tbl_data still holds this entry
                dev_d   = tbl_data[22:16];
                reg_d   = tbl_data[15:8];
                val_d   = tbl_data[7:0];
                req_d   = 1'b1;
                state_d = StWaitI2c;
            end
            StWaitI2c: begin
                if (i2c_done) begin
                    req_d = 1'b0;
                    if (!i2c_nack) begin
                        retry_d = '0;
                        state_d = StNext;
                    end else if (retry_q < MaxRetry) begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StWrite;
                    end else begin
                        err_d   = 1'b1;
                        erra_d  = addr_q;
                        state_d = StErr;
                    end
                end
            end
            StDelay: begin
                // Inner counter runs TICK_CYC cycles per tick; total = ticks * TICK_CYC
                if (cyc_q <= 16'd1) begin
                    if (tick_q <= 16'd1) begin
                        state_d = StNext;
                    end else begin
                        tick_d = tick_q - 16'd1;
                        cyc_d  = TICK_CYC;
                    end
                end else begin
                    cyc_d = cyc_q - 16'd1;
                end
            end
            StNext: begin
                if (addr_q == {TBL_AW{1'b1}}) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + TBL_AW'(1);
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            retry_q <= '0;
            req_q   <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            erra_q  <= '0;
            auto_q  <= AUTO_START;
            pwr_q   <= '0;
            tick_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            retry_q <= retry_d;
            req_q   <= req_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            done_q  <= done_d;
            err_q   <= err_d;
            erra_q  <= erra_d;
            auto_q  <= auto_d;
            pwr_q   <= pwr_d;
            tick_q  <= tick_d;
            cyc_q   <= cyc_d;
        end
    end

    assign tbl_addr  = addr_q;
    assign i2c_req   = req_q;
    assign i2c_dev   = dev_q;
    assign i2c_reg   = reg_q;
    assign i2c_wdata = val_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_addr  = erra_q;
    assign busy      = !(state_q inside {StIdle, StDone, StErr});

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
module tb_hdmi_cfg_seq;

    localparam int unsigned AW    = 2;
    localparam int          DEPTH = 4;
    localparam logic [19:0] PWR   = 20'd10;
    localparam logic [15:0] TICK  = 16'd4;
    localparam int          MR    = 3;
    localparam int          LIMIT = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (auto start) and a second instance with AUTO_START=0
    logic          rst, start;
    logic [AW-1:0] tbl_addr, err_addr;
    logic [24:0]   tbl_data;
    logic          i2c_req, i2c_done, i2c_nack, busy, cfg_done, cfg_err;
    logic [6:0]    i2c_dev;
    logic [7:0]    i2c_reg, i2c_wdata;

    logic          rst2, start2;
    logic [AW-1:0] tbl_addr2, err_addr2;
    logic [24:0]   tbl_data2;
    logic          i2c_req2, i2c_done2, i2c_nack2, busy2, cfg_done2, cfg_err2;
    logic [6:0]    i2c_dev2;
    logic [7:0]    i2c_reg2, i2c_wdata2;

    hdmi_cfg_seq #(
        .TBL_AW(AW), .PWRUP_CYC(PWR), .TICK_CYC(TICK), .MAX_RETRY(MR), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .busy(busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .err_addr(err_addr)
    );

    hdmi_cfg_seq #(
        .TBL_AW(AW), .PWRUP_CYC(PWR), .TICK_CYC(TICK), .MAX_RETRY(MR), .AUTO_START(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
        .i2c_req(i2c_req2), .i2c_dev(i2c_dev2), .i2c_reg(i2c_reg2), .i2c_wdata(i2c_wdata2),
        .i2c_done(i2c_done2), .i2c_nack(i2c_nack2), .busy(busy2), .cfg_done(cfg_done2),
        .cfg_err(cfg_err2), .err_addr(err_addr2)
    );

    // Synchronous ROM shared by both instances
    logic [24:0] rom [DEPTH];
    int          nacks [DEPTH];
    always @(posedge clk) begin
        tbl_data  <= rom[tbl_addr];
        tbl_data2 <= rom[tbl_addr2];
    end

    typedef struct {
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] val;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    bit   nack_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [24:0] mk(input logic [1:0] op, input logic [6:0] d,
                                       input logic [7:0] r, input logic [7:0] v);
        return {op, d, r, v};
    endfunction

    // Reference model: expected request stream (fields + edges since the
    // triggering start/done edge), the responder's NACK plan, and the outcome.
    task automatic model(output bit e_err, output int e_addr);
        int          gap;
        int          ticks;
        logic [24:0] w;
        exp_t        e;
        gap    = int'(PWR) + 3;
        e_err  = 1'b0;
        e_addr = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            w = rom[a];
            case (w[24:23])
                2'b10: begin
                    e_addr = a;
                    return;
                end
                2'b11: gap += 3;
                2'b01: begin
                    ticks = int'(w[15:0]);
                    gap += 3 + ticks * int'(TICK);
                end
                default: begin
                    for (int k = 0; k <= MR; k++) begin
                        e.dev = w[22:16];
                        e.rg  = w[15:8];
                        e.val = w[7:0];
                        e.gap = (k == 0) ? gap : 1;
                        exp_q.push_back(e);
                        nack_q.push_back(k < nacks[a]);
                        if (k >= nacks[a]) break;
                    end
                    if (nacks[a] > MR) begin
                        e_err  = 1'b1;
                        e_addr = a;
                        return;
                    end
                    gap = 4;
                end
            endcase
        end
    endtask

    // I2C responder for the main DUT: answers each request after a random delay
    initial begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_req && !rst) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                i2c_done = 1'b1;
                i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                @(negedge clk);
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every rising i2c_req
    int   cyc      = 0;
    int   ref_cyc  = 0;
    bit   req_prev = 1'b0;
    bit   rst_prev = 1'b1;
    bit   ev;
    exp_t got;
    always begin
        @(posedge clk);
        ev       = start || i2c_done || (rst_prev && !rst);
        rst_prev = rst;
        cyc++;
        if (ev) ref_cyc = cyc;
        #1;
        if (!rst && i2c_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                got = exp_q.pop_front();
                chk("req_dev", 64'(i2c_dev), 64'(got.dev));
                chk("req_reg", 64'(i2c_reg), 64'(got.rg));
                chk("req_val", 64'(i2c_wdata), 64'(got.val));
                chk("req_gap", 64'(cyc - ref_cyc), 64'(got.gap));
            end
        end
        req_prev = rst ? 1'b0 : i2c_req;
    end

    task automatic run_wait();
        int n = 0;
        @(posedge clk);
        #1;
        while (busy && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("run_timeout", 64'(n < LIMIT), 1);
        chk("leftover_req", 64'(exp_q.size()), 0);
        exp_q.delete();
        nack_q.delete();
    endtask

    task automatic do_run(input bit use_start);
        bit e_err;
        int e_addr;
        model(e_err, e_addr);
        if (use_start) begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            chk("start_clr_done", 64'(cfg_done), 0);
            chk("start_clr_err", 64'(cfg_err), 0);
            chk("start_clr_erra", 64'(err_addr), 0);
            chk("start_busy", 64'(busy), 1);
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
            rst = 1'b0;
        end
        run_wait();
        chk("cfg_done", 64'(cfg_done), 64'(!e_err));
        chk("cfg_err", 64'(cfg_err), 64'(e_err));
        chk("err_addr", 64'(err_addr), e_err ? 64'(e_addr) : 64'd0);
        chk("tbl_addr_end", 64'(tbl_addr), 64'(e_addr));
        chk("req_low_end", 64'(i2c_req), 0);
    endtask

    task automatic clr_nacks();
        for (int i = 0; i < DEPTH; i++) nacks[i] = 0;
    endtask

    task automatic wait_req2(input string name, input int req_lat);
        int n = 0;
        while (!i2c_req2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(n), 64'(req_lat));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        rst2      = 1'b1;
        start2    = 1'b0;
        i2c_done2 = 1'b0;
        i2c_nack2 = 1'b0;
        clr_nacks();

        // Two writes then END; first req P+3 edges after the release edge
        rom[0] = mk(2'b00, 7'h39, 8'h08, 8'h35);
        rom[1] = mk(2'b00, 7'h39, 8'h2F, 8'h00);
        rom[2] = mk(2'b10, 7'h00, 8'h00, 8'h00);
        rom[3] = mk(2'b11, 7'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 64'(i2c_req), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(cfg_done), 0);
        chk("rst_err", 64'(cfg_err), 0);
        chk("rst_erra", 64'(err_addr), 0);
        chk("rst_addr", 64'(tbl_addr), 0);
        chk("rst_dev", 64'({i2c_dev, i2c_reg, i2c_wdata}), 0);
        do_run(1'b0);

        // Delay of 3 ticks between two writes
        rom[0] = mk(2'b00, 7'h39, 8'hC7, 8'h00);
        rom[1] = mk(2'b01, 7'h00, 8'h00, 8'h03);
        rom[2] = mk(2'b00, 7'h3D, 8'h01, 8'h01);
        rom[3] = mk(2'b10, 7'h00, 8'h00, 8'h00);
        do_run(1'b1);

        // Entry 1 NACKed twice then acked
        rom[0] = mk(2'b00, 7'h39, 8'h08, 8'h35);
        rom[1] = mk(2'b00, 7'h39, 8'h2F, 8'h00);
        rom[2] = mk(2'b00, 7'h39, 8'h3E, 8'h11);
        rom[3] = mk(2'b10, 7'h00, 8'h00, 8'h00);
        nacks[1] = 2;
        do_run(1'b1);

        // Entry 2 always NACKed -> error, then replay cleanly
        clr_nacks();
        nacks[2] = 4;
        do_run(1'b1);
        clr_nacks();
        do_run(1'b1);

        // Four writes, implicit end; then NOP in slot 1
        rom[3] = mk(2'b00, 7'h72, 8'h55, 8'hAA);
        do_run(1'b1);
        rom[1] = mk(2'b11, 7'h39, 8'h2F, 8'h00);
        do_run(1'b1);

        // Randomised tables and NACK plans
        for (int it = 0; it < 30; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int r;
                int s;
                r = $urandom_range(0, 9);
                s = $urandom_range(0, 9);
                if (r < 6)      rom[a] = mk(2'b00, 7'($urandom), 8'($urandom), 8'($urandom));
                else if (r < 8) rom[a] = mk(2'b01, 7'($urandom), 8'h00, 8'($urandom_range(0, 3)));
                else if (r < 9) rom[a] = mk(2'b11, 7'($urandom), 8'($urandom), 8'($urandom));
                else            rom[a] = mk(2'b10, 7'($urandom), 8'($urandom), 8'($urandom));
                nacks[a] = (s < 6) ? 0 : s - 5;
            end
            do_run(1'b1);
        end

        // Reset mid-transfer on the AUTO_START=0 instance
        rom[0] = mk(2'b00, 7'h39, 8'h08, 8'h35);
        rom[1] = mk(2'b10, 7'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst2 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_no_auto_busy", 64'(busy2), 0);
        chk("t6_no_auto_req", 64'(i2c_req2), 0);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_req2("t6_req_lat_a", int'(PWR) + 3);
        @(negedge clk);
        rst2      = 1'b1;
        i2c_done2 = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_req", 64'(i2c_req2), 0);
        chk("t6_rst_busy", 64'(busy2), 0);
        chk("t6_rst_addr", 64'(tbl_addr2), 0);
        chk("t6_rst_stat", 64'({cfg_done2, cfg_err2, err_addr2}), 0);
        chk("t6_rst_flds", 64'({i2c_dev2, i2c_reg2, i2c_wdata2}), 0);
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        i2c_done2 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_idle_busy", 64'(busy2), 0);
        chk("t6_idle_req", 64'(i2c_req2), 0);
        chk("t6_idle_done", 64'(cfg_done2), 0);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_req2("t6_req_lat_b", int'(PWR) + 3);
        chk("t6_dev", 64'({i2c_dev2, i2c_reg2, i2c_wdata2}), 64'h39_08_35);
        @(negedge clk);
        i2c_done2 = 1'b1;
        @(negedge clk);
        i2c_done2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_cfg_done", 64'(cfg_done2), 1);
        chk("t6_busy_end", 64'(busy2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
